cache_req_issuer: RTL and testbench

// CPU-side initiator for the cache. Accepts one load/store at a time via a valid/ready handshake,

---
 rtl/cache_req_issuer_if.sv | 50 +++++
 rtl/cache_req_issuer.sv | 155 +++++++++++++++
 tb/tb_cache_req_issuer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_req_issuer_if.sv
`default_nettype none
// ============================================================================
//  Module   : cache_req_issuer_if
//  Purpose  : Bundles the request, cache-side and response signals of the
//             cache request issuer. The master modport is the issuer's view
//             and the slave modport is the view of the core and cache around it.
//  Revision : 1.0  initial release
// ============================================================================
interface cache_req_issuer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
);
    localparam int LAT_W = $clog2(TIMEOUT + 1);

    // upstream request
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    // cache side
    logic                  re;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  done;
    // downstream response
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_write;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic [LAT_W-1:0]      resp_latency;
    logic                  spurious_done;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rdata, done, resp_ready,
        output req_ready, re, we, addr, wdata,
        output resp_valid, resp_write, resp_rdata, resp_err, resp_latency, spurious_done
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rdata, done, resp_ready,
        input  req_ready, re, we, addr, wdata,
        input  resp_valid, resp_write, resp_rdata, resp_err, resp_latency, spurious_done
    );
endinterface
`default_nettype wire

// File: rtl/cache_req_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : cache_req_issuer
//  Purpose  : CPU-side cache initiator. Takes one load/store at a time,
//             strobes the cache for one cycle, waits for done (with a
//             watchdog), and returns data, latency and an error flag.
//  Revision : 1.0  initial release
// ============================================================================
module cache_req_issuer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic               clk,
    input  logic               rst,
    cache_req_issuer_if.master bus
);
    localparam int LAT_W = $clog2(TIMEOUT + 1);
    localparam logic [LAT_W-1:0] TIMEOUT_CNT = LAT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [LAT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic [LAT_W-1:0]      resp_latency_q;
    logic                  resp_err_q;
    logic                  spurious_q;

    logic                  req_ready_c;
    logic                  re_c;
    logic                  we_c;
    logic                  resp_valid_c;

    logic                  wait_expired;
    assign wait_expired = (cnt == TIMEOUT_CNT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded handshake/strobe outputs
    always_comb begin
        state_next   = state;
        req_ready_c  = 1'b0;
        re_c         = 1'b0;
        we_c         = 1'b0;
        resp_valid_c = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                re_c       = ~write_q;
                we_c       = write_q;
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.done || wait_expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, latency counting and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q        <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            cnt            <= '0;
            resp_rdata_q   <= '0;
            resp_latency_q <= '0;
            resp_err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // addr/wdata keep their last value until a new request lands
                    if (bus.req_valid) begin
                        write_q <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                    end
                end
                ISSUE: begin
                    cnt <= LAT_W'(1);
                end
                WAIT: begin
                    // done wins over the watchdog, so done at exactly TIMEOUT is good
                    if (bus.done) begin
                        resp_rdata_q   <= write_q ? '0 : bus.rdata;
                        resp_latency_q <= cnt;
                        resp_err_q     <= 1'b0;
                    end else if (wait_expired) begin
                        resp_rdata_q   <= '0;
                        resp_latency_q <= TIMEOUT_CNT;
                        resp_err_q     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky flag for a done that arrives when no access is outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            spurious_q <= 1'b0;
        end else if (bus.done && (state != WAIT)) begin
            spurious_q <= 1'b1;
        end
    end

    assign bus.req_ready     = req_ready_c;
    assign bus.re            = re_c;
    assign bus.we            = we_c;
    assign bus.addr          = addr_q;
    assign bus.wdata         = wdata_q;
    assign bus.resp_valid    = resp_valid_c;
    assign bus.resp_write    = write_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_err      = resp_err_q;
    assign bus.resp_latency  = resp_latency_q;
    assign bus.spurious_done = spurious_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_req_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_req_issuer
//  Purpose  : Self-checking bench for cache_req_issuer. A small cache model
//             answers strobes after a chosen delay; expected responses go
//             into a scoreboard and are compared on the response handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cache_req_issuer;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 8;
    localparam int TIMEOUT    = 15;
    localparam int LAT_W      = $clog2(TIMEOUT + 1);

    typedef struct {
        logic                  write;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic [LAT_W-1:0]      lat;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    cache_req_issuer_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) bus ();

    cache_req_issuer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change just after a rising edge; outputs are observed on the falling edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: a response is taken on the next rising edge when both are high
    always @(negedge clk) begin
        if (bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_write",   bus.resp_write,   e.write);
                check("resp_rdata",   bus.resp_rdata,   e.rdata);
                check("resp_err",     bus.resp_err,     e.err);
                check("resp_latency", bus.resp_latency, e.lat);
            end
        end
    end

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready",  bus.req_ready,     1);
        check("rst_resp_valid", bus.resp_valid,    0);
        check("rst_re_we",      {bus.re, bus.we},  0);
        check("rst_addr",       bus.addr,          0);
        check("rst_wdata",      bus.wdata,         0);
        check("rst_rdata",      bus.resp_rdata,    0);
        check("rst_err",        bus.resp_err,      0);
        check("rst_latency",    bus.resp_latency,  0);
        check("rst_spurious",   bus.spurious_done, 0);
    endtask

    // One full access. dly = cycles after the issue cycle at which done is
    // driven (negative: never). hold = extra cycles of response backpressure.
    task automatic access(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                          input logic [7:0] rd, input int dly, input logic spur_issue,
                          input int hold);
        exp_t e;
        int   c;
        int   c_exp;
        logic got_resp;
        e.write = wr;
        e.err   = (dly < 0) || (dly > TIMEOUT);
        e.rdata = (e.err || wr) ? 8'h00 : rd;
        e.lat   = e.err ? LAT_W'(TIMEOUT) : LAT_W'(dly);
        c_exp   = e.err ? TIMEOUT + 1 : dly + 1;
        sb.push_back(e);

        next_cycle();
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check("req_ready_idle", bus.req_ready, 1);

        got_resp = 1'b0;
        c = 0;
        while (c <= TIMEOUT + 3 && !got_resp) begin
            next_cycle();
            bus.req_valid = 1'b0;
            bus.done      = (c == dly) || (spur_issue && c == 0);
            bus.rdata     = (c == dly) ? rd : ~rd;
            @(negedge clk);
            if (bus.resp_valid) begin
                got_resp = 1'b1;
            end else begin
                check("re",        bus.re,        (c == 0) && !wr);
                check("we",        bus.we,        (c == 0) && wr);
                check("addr_held", bus.addr,      a);
                check("wdata_held", bus.wdata,    wd);
                check("req_ready_busy", bus.req_ready, 0);
                c++;
            end
        end
        next_cycle();
        bus.done = 1'b0;
        check("resp_arrived", got_resp, 1);
        check("resp_cycle",   c, c_exp);

        // Backpressure: response must hold and a pending request must not be taken
        for (int h = 0; h < hold; h++) begin
            bus.req_valid = 1'b1;
            @(negedge clk);
            check("bp_resp_valid", bus.resp_valid,   1);
            check("bp_req_ready",  bus.req_ready,    0);
            check("bp_rdata",      bus.resp_rdata,   e.rdata);
            check("bp_latency",    bus.resp_latency, e.lat);
            check("bp_err",        bus.resp_err,     e.err);
            check("bp_addr",       bus.addr,         a);
            next_cycle();
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        next_cycle();
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check("post_resp_valid", bus.resp_valid, 0);
        check("post_req_ready",  bus.req_ready,  1);
        check("post_addr_kept",  bus.addr,       a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rdata      = '0;
        bus.done       = 1'b0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Spurious done while idle: sticky, FSM stays put
        next_cycle();
        bus.done = 1'b1;
        next_cycle();
        bus.done = 1'b0;
        @(negedge clk);
        check("spur_idle_flag",  bus.spurious_done, 1);
        check("spur_idle_ready", bus.req_ready,     1);
        check("spur_idle_resp",  bus.resp_valid,    0);

        // Spurious done in the issue cycle; the real done still completes
        access(1'b0, 8'h21, 8'h00, 8'h5A, 3, 1'b1, 0);
        check("spur_issue_flag", bus.spurious_done, 1);
        do_reset();

        access(1'b0, 8'h12, 8'h00, 8'hA5, 2,  1'b0, 0);   // load hit
        access(1'b1, 8'h40, 8'h3C, 8'h77, 3,  1'b0, 0);   // store miss
        access(1'b0, 8'h55, 8'h00, 8'h99, -1, 1'b0, 0);   // timeout
        access(1'b0, 8'h56, 8'h00, 8'hC3, 15, 1'b0, 0);   // done at the limit
        access(1'b0, 8'h90, 8'h11, 8'h6E, 4,  1'b0, 5);   // backpressure
        access(1'b1, 8'h91, 8'hE7, 8'h00, -1, 1'b0, 1);   // store timeout

        for (int i = 0; i < 6; i++) begin
            access(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(2, 14)), 1'b0, int'($urandom_range(0, 2)));
        end
        check("no_spurious", bus.spurious_done, 0);

        // Reset while waiting: access aborted, late done is spurious
        next_cycle();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h77;
        bus.resp_ready = 1'b1;
        next_cycle();
        bus.req_valid = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rstw_req_ready",  bus.req_ready,     1);
        check("rstw_resp_valid", bus.resp_valid,    0);
        check("rstw_strobes",    {bus.re, bus.we},  0);
        next_cycle();
        bus.done = 1'b1;
        next_cycle();
        bus.done = 1'b0;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check("rstw_spurious",   bus.spurious_done, 1);
        check("rstw_no_resp",    bus.resp_valid,    0);
        check("rstw_idle",       bus.req_ready,     1);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
